// File: rtl/fpu_issue.sv
// fpu_issue: dispatches one CPU command to a selected FPU unit and returns its result, with timeout and bad-op handling.
module fpu_issue #(
  parameter int N_UNITS = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [31:0]  cmd_x1,
  input  logic [31:0]  cmd_x2,
  output logic [31:0]  unit_x1,
  output logic [31:0]  unit_x2,
  output logic [7:0]   unit_ready,
  input  logic [7:0]   unit_valid,
  input  logic [255:0] unit_y,
  output logic         res_valid,
  output logic [31:0]  res_data,
  output logic         res_err,
  input  logic         res_ack,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [2:0] op;
  logic [7:0] cnt;
  logic hit, bad;
  logic [31:0] y;
  assign hit = unit_valid[op];
  assign y = unit_y[{op, 5'b0} +: 32];
  assign bad = int'(op) >= N_UNITS;
  assign cmd_ready = (state == IDLE) && !rst;
  assign unit_ready = (state == ISSUE && !bad) ? 8'b1 << op : 8'b0;
  assign res_valid = state == DONE;
  assign busy = state != IDLE;
  // Valid is tested before the counter so a result in the last WAIT cycle beats the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      res_data <= '0;
      res_err <= 1'b0;
      op <= '0;
      unit_x1 <= '0;
      unit_x2 <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op <= cmd_op;
          unit_x1 <= cmd_x1;
          unit_x2 <= cmd_x2;
          state <= ISSUE;
        end
        ISSUE: if (bad || hit) begin
          res_data <= bad ? 32'b0 : y;
          res_err <= bad;
          state <= DONE;
        end else begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (hit || cnt == 8'(TIMEOUT - 1)) begin
          res_data <= hit ? y : 32'b0;
          res_err <= !hit;
          state <= DONE;
        end else cnt <= cnt + 8'd1;
        DONE: if (res_ack) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed checks of fpu_issue with default parameters (d0) and N_UNITS=4, TIMEOUT=3 (d1).
module tb_fpu_issue;
  logic clk, rst, cv0, cv1, res_ack;
  logic [2:0] cmd_op;
  logic [31:0] cmd_x1, cmd_x2;
  logic [7:0] uv;
  logic [255:0] uy;
  logic rdy0, rv0, re0, bz0, rdy1, rv1, re1, bz1;
  logic [7:0] ur0, ur1;
  logic [31:0] rd0, rd1, ux10, ux20, ux11, ux21;
  int total = 0, passed = 0;
  fpu_issue d0 (
    .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(rdy0), .cmd_op(cmd_op),
    .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .unit_x1(ux10), .unit_x2(ux20),
    .unit_ready(ur0), .unit_valid(uv), .unit_y(uy), .res_valid(rv0),
    .res_data(rd0), .res_err(re0), .res_ack(res_ack), .busy(bz0)
  );
  fpu_issue #(.N_UNITS(4), .TIMEOUT(3)) d1 (
    .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_op(cmd_op),
    .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .unit_x1(ux11), .unit_x2(ux21),
    .unit_ready(ur1), .unit_valid(uv), .unit_y(uy), .res_valid(rv1),
    .res_data(rd1), .res_err(re1), .res_ack(res_ack), .busy(bz1)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ack();
    res_ack = 1;
    step();
    res_ack = 0;
  endtask
  initial begin
    rst = 1; cv0 = 0; cv1 = 0; res_ack = 0; cmd_op = 0; cmd_x1 = 0; cmd_x2 = 0; uv = 0; uy = '0;
    step();
    step();
    chk("rst_cmd_ready", rdy0, 0);
    chk("rst_res_valid", rv0, 0);
    chk("rst_unit_ready", ur0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_res_data", rd0, 0);
    rst = 0;
    #1;
    chk("post_rst_cmd_ready", rdy0, 1);
    // op 2, combinational unit
    res_ack = 1;
    step();
    res_ack = 0;
    chk("ack_idle_ignored", bz0, 0);
    cmd_op = 2; cmd_x1 = 32'h11112222; cmd_x2 = 32'h33334444; cv0 = 1;
    uy[95:64] = 32'h00000001;
    step();
    cv0 = 0; cmd_x1 = 0; cmd_x2 = 0;
    uv = 8'h04;
    chk("op2_strobe", ur0, 8'h04);
    chk("op2_x1", ux10, 32'h11112222);
    chk("op2_x2", ux20, 32'h33334444);
    chk("op2_busy", bz0, 1);
    chk("op2_no_cmd_ready", rdy0, 0);
    chk("op2_no_early_valid", rv0, 0);
    step();
    uv = 0;
    chk("op2_res_valid", rv0, 1);
    chk("op2_res_data", rd0, 32'h1);
    chk("op2_res_err", re0, 0);
    chk("op2_strobe_gone", ur0, 0);
    ack();
    chk("op2_idle", rdy0, 1);
    chk("op2_not_busy", bz0, 0);
    // op 5, valid 4 cycles after strobe, with stray valids and an early ack
    cmd_op = 5; cmd_x1 = 32'h40000000; cv0 = 1;
    uy[191:160] = 32'h3F800000;
    step();
    cv0 = 0;
    chk("op5_strobe", ur0, 8'h20);
    for (int c = 2; c <= 5; c++) begin
      step();
      uv = (c == 3) ? 8'h01 : (c == 5) ? 8'h20 : 8'h00;
      res_ack = (c == 4);
      chk("op5_strobe_once", ur0, 0);
      chk("op5_wait_no_valid", rv0, 0);
      chk("op5_x1_held", ux10, 32'h40000000);
    end
    step();
    uv = 0; res_ack = 0;
    chk("op5_res_valid", rv0, 1);
    chk("op5_res_data", rd0, 32'h3F800000);
    chk("op5_res_err", re0, 0);
    uy[191:160] = 32'hDEADBEEF;
    for (int c = 0; c < 10; c++) begin
      step();
      uv = 8'h20;
      chk("hold_valid", rv0, 1);
      chk("hold_data", rd0, 32'h3F800000);
      chk("hold_cmd_ready", rdy0, 0);
    end
    uv = 0;
    ack();
    chk("after_ack_ready", rdy0, 1);
    cmd_op = 3; cv0 = 1;
    uy[127:96] = 32'h12345678;
    step();
    cv0 = 0; uv = 8'h08;
    chk("b2b_strobe", ur0, 8'h08);
    step();
    uv = 0;
    chk("b2b_valid", rv0, 1);
    chk("b2b_data", rd0, 32'h12345678);
    ack();
    // reset while waiting
    cmd_op = 4; cv0 = 1;
    step();
    cv0 = 0;
    step();
    step();
    chk("abort_in_wait", bz0, 1);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("abort_cmd_ready", rdy0, 1);
    for (int c = 0; c < 4; c++) begin
      uv = (c % 2 == 0) ? 8'h10 : 8'h00;
      step();
      chk("abort_no_valid", rv0, 0);
      chk("abort_not_busy", bz0, 0);
      chk("abort_no_strobe", ur0, 0);
    end
    uv = 0;
    // d1: valid in final WAIT cycle wins
    cmd_op = 1; cv1 = 1;
    uy[63:32] = 32'hCAFEF00D;
    step();
    cv1 = 0;
    chk("d1_strobe", ur1, 8'h02);
    step();
    step();
    step();
    uv = 8'h02;
    chk("d1_last_wait", rv1, 0);
    step();
    uv = 0;
    chk("d1_late_valid", rv1, 1);
    chk("d1_late_data", rd1, 32'hCAFEF00D);
    chk("d1_late_err", re1, 0);
    ack();
    // d1: timeout
    cv1 = 1;
    step();
    cv1 = 0;
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("d1_to_waiting", rv1, 0);
    end
    step();
    chk("d1_to_valid", rv1, 1);
    chk("d1_to_data", rd1, 0);
    chk("d1_to_err", re1, 1);
    ack();
    chk("d1_to_idle", rdy1, 1);
    // d1: op beyond N_UNITS
    cmd_op = 6; cv1 = 1;
    uy[223:192] = 32'h55555555;
    step();
    cv1 = 0; uv = 8'h40;
    chk("d1_bad_no_strobe", ur1, 0);
    step();
    uv = 0;
    chk("d1_bad_valid", rv1, 1);
    chk("d1_bad_err", re1, 1);
    chk("d1_bad_data", rd1, 0);
    chk("d1_bad_strobe_still0", ur1, 0);
    ack();
    chk("d0_untouched", bz0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter N_UNITS, default 8, number of attached FPU units (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before declaring a unit dead (1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  CPU presents a command.
REQ-006 SHALL have port cmd_ready  output  1  block accepts a command this cycle.
REQ-007 SHALL have port cmd_op  input  3  target unit index.
REQ-008 SHALL have ports cmd_x1, cmd_x2  input  32 each  operands.
REQ-009 SHALL have ports unit_x1, unit_x2  output  32 each  operands broadcast to all units.
REQ-010 SHALL have port unit_ready  output  8  one-hot start strobe, bit i to unit i.
REQ-011 SHALL have port unit_valid  input  8  completion from unit i.
REQ-012 SHALL have port unit_y  input  256  unit i result on bits [32i+31:32i].
REQ-013 SHALL have port res_valid  output  1  result available to CPU.
REQ-014 SHALL have port res_data  output  32  captured result.
REQ-015 SHALL have port res_err  output  1  result invalid (timeout or bad op).
REQ-016 SHALL have port res_ack  input  1  CPU consumes result.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-019 cmd_ready SHALL equal (state==IDLE) and not rst; no other state accepts commands.
REQ-020 IDLE with cmd_valid SHALL latch cmd_op, cmd_x1, cmd_x2 and go to ISSUE; otherwise stay.
REQ-021 unit_x1/unit_x2 SHALL drive the latched operands, held stable from ISSUE until leaving WAIT.
REQ-022 ISSUE SHALL assert unit_ready[op] for exactly one cycle; all other unit_ready bits 0 in all states.
REQ-023 ISSUE with unit_valid[op]=1 in the same cycle (combinational unit) SHALL capture unit_y[op], clear err, go to DONE.
REQ-024 ISSUE without unit_valid[op] SHALL clear the wait counter and go to WAIT.
REQ-025 WAIT with unit_valid[op] SHALL capture unit_y[op], clear err, go to DONE.
REQ-026 WAIT without valid SHALL increment the 8-bit counter; at TIMEOUT WAIT cycles without valid SHALL go to DONE with res_data=0, res_err=1.
REQ-027 Valid arriving in the final (TIMEOUT-th) WAIT cycle SHALL win over timeout.
REQ-028 Latched op >= N_UNITS SHALL bypass strobing: ISSUE goes directly to DONE with res_data=0, res_err=1, unit_ready all 0.
REQ-029 Latency: command accepted cycle 0, strobe cycle 1, unit valid at cycle 1+k (0<=k<=TIMEOUT) gives res_valid at cycle 2+k.
REQ-030 DONE SHALL assert res_valid with res_data/res_err held stable until res_ack; res_ack then returns to IDLE next cycle.
REQ-031 res_ack while res_valid low SHALL be ignored.
REQ-032 unit_valid bits other than [op], and any unit_valid in IDLE or DONE, SHALL be ignored.
REQ-033 Back-to-back throughput: one command per 3+k cycles (IDLE, ISSUE, WAIT x k, DONE).

Reset
REQ-034 While rst=1 at a clock edge: state=IDLE, counter=0, res_data=0, res_err=0, latched op/operands=0.
REQ-035 During and after reset: res_valid=0, unit_ready=0, busy=0; cmd_ready=0 while rst=1, 1 in the first cycle after.
REQ-036 Reset mid-operation (ISSUE/WAIT/DONE) SHALL abort without a result; a late unit_valid afterwards SHALL be ignored.

Verification
REQ-037 Op 2, unit 2 valid=ready combinationally, unit_y[95:64]=0x00000001 -> res_valid at cycle 2, res_data=0x00000001, res_err=0.
REQ-038 Op 5, unit 5 valid 4 cycles after strobe, y=0x3F800000 -> unit_ready=0x20 for one cycle only, res_valid at cycle 6, data 0x3F800000.
REQ-039 TIMEOUT=3, op 1, unit never valid -> res_valid at cycle 5, res_data=0, res_err=1; valid at cycle 4 instead -> data captured, err=0.
REQ-040 N_UNITS=4, op 6 -> unit_ready stays 0, res_valid at cycle 2 with res_err=1.
REQ-041 res_ack held low 10 cycles then pulsed -> res_data stable, cmd_ready=0 throughout, IDLE next cycle; second command accepted right after.
REQ-042 rst asserted in WAIT, then unit_valid pulses -> res_valid never asserts, busy=0, cmd_ready=1 after rst drops.
